axi_master_rr_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one simple_axi_master command port among N_REQ requesters.

---
 rtl/simple_axi_pkg.sv | 30 +++
 rtl/axi_master_rr_arbiter_rr_pick.sv | 32 +++
 rtl/axi_master_rr_arbiter.sv | 161 ++++++++++++++++
 tb/tb_axi_master_rr_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_axi_pkg.sv
// rtl/simple_axi_pkg.sv - shared command, size and arbiter-state types for the simple AXI master path
package simple_axi_pkg;

    typedef enum logic [1:0] {
        RW_IDLE   = 2'b00,
        RW_WRITE  = 2'b01,
        RW_READ   = 2'b10,
        RW_IGNORE = 2'b11
    } rw_cmd_e;

    typedef enum logic [2:0] {
        SIZE_BYTE  = 3'd0,
        SIZE_HALF  = 3'd1,
        SIZE_WORD  = 3'd2,
        SIZE_DWORD = 3'd3
    } transfer_size_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } arb_state_e;

    // 11 is a reserved encoding and never counts as a request
    function automatic logic is_pending(input logic [1:0] rw);
        return (rw == RW_WRITE) || (rw == RW_READ);
    endfunction

endpackage

// File: rtl/axi_master_rr_arbiter_rr_pick.sv
// rtl/axi_master_rr_arbiter_rr_pick.sv - first pending index searching upward from a pointer with wrap
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         i_pending,
    input  logic [$clog2(N_REQ)-1:0] i_ptr,
    output logic                     o_valid,
    output logic [$clog2(N_REQ)-1:0] o_idx
);

    localparam int IW = $clog2(N_REQ);

    logic [IW:0] cand;

    // Walk offsets from farthest to nearest so the nearest pending index is the last one written
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        cand    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, i_ptr} + (IW + 1)'(i);
            if (cand >= (IW + 1)'(N_REQ)) begin
                cand = cand - (IW + 1)'(N_REQ);
            end
            if (i_pending[cand[IW-1:0]]) begin
                o_valid = 1'b1;
                o_idx   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/axi_master_rr_arbiter.sv
// rtl/axi_master_rr_arbiter.sv - round-robin sequencer sharing one single-beat AXI master among requesters
module axi_master_rr_arbiter
    import simple_axi_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic [2*N_REQ-1:0]     i_req_rw,
    input  logic [3*N_REQ-1:0]     i_req_size,
    input  logic [32*N_REQ-1:0]    i_req_addr,
    input  logic [WIDTH*N_REQ-1:0] i_req_wdata,
    output logic [N_REQ-1:0]       o_req_grant,
    output logic [N_REQ-1:0]       o_req_done,
    output logic                   o_req_error,
    output logic                   o_req_invalid,
    output logic [WIDTH-1:0]       o_req_rdata,
    output logic [1:0]             o_m_rw,
    output logic [2:0]             o_m_size,
    output logic [31:0]            o_m_addr,
    output logic [WIDTH-1:0]       o_m_wdata,
    output logic                   o_m_clear,
    input  logic [WIDTH-1:0]       i_m_rdata,
    input  logic                   i_m_wait,
    input  logic                   i_m_done,
    input  logic                   i_m_error,
    input  logic                   i_m_invalid
);

    localparam int IW = $clog2(N_REQ);

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [1:0]       rw_q, rw_d;
    logic [2:0]       size_q, size_d;
    logic [31:0]      addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             inv_q, inv_d;

    logic [N_REQ-1:0] pending;
    logic             pick_valid;
    logic [IW-1:0]    pick_idx;
    logic [N_REQ-1:0] idx_onehot;

    always_comb begin
        pending = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pending[k] = is_pending(i_req_rw[2*k +: 2]);
        end
    end

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .i_pending (pending),
        .i_ptr     (rr_ptr_q),
        .o_valid   (pick_valid),
        .o_idx     (pick_idx)
    );

    assign idx_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << idx_q;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            rr_ptr_q <= '0;
            rw_q     <= '0;
            size_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
            rw_q     <= rw_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            inv_q    <= inv_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rr_ptr_d    = rr_ptr_q;
        rw_d        = rw_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        inv_d       = inv_q;
        o_m_rw      = 2'b00;
        o_m_clear   = 1'b0;
        o_req_grant = '0;
        o_req_done  = '0;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    idx_d   = pick_idx;
                    rw_d    = i_req_rw[{pick_idx, 1'b0} +: 2];
                    size_d  = i_req_size[3*int'(pick_idx) +: 3];
                    addr_d  = i_req_addr[32*int'(pick_idx) +: 32];
                    wdata_d = i_req_wdata[WIDTH*int'(pick_idx) +: WIDTH];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_m_rw      = rw_q;
                o_req_grant = idx_onehot;
                // A done here is the master refusing a misaligned command without bus traffic
                if (i_m_done) begin
                    rdata_d = '0;
                    err_d   = i_m_error;
                    inv_d   = i_m_invalid;
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                o_req_grant = idx_onehot;
                if (i_m_done) begin
                    rdata_d = i_m_rdata;
                    err_d   = i_m_error;
                    inv_d   = i_m_invalid;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                o_req_grant = idx_onehot;
                o_req_done  = idx_onehot;
                o_m_clear   = 1'b1;
                rr_ptr_d    = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_m_size      = size_q;
    assign o_m_addr      = addr_q;
    assign o_m_wdata     = wdata_q;
    assign o_req_rdata   = rdata_q;
    assign o_req_error   = err_q;
    assign o_req_invalid = inv_q;

    // The master must report busy for as long as we are waiting on it
    a_wait_while_busy: assert property (@(posedge i_clk) disable iff (!i_rstn)
        (state_q == S_WAIT) |-> i_m_wait);

endmodule

// File: tb/tb_axi_master_rr_arbiter.sv
// tb/tb_axi_master_rr_arbiter.sv - directed self-checking bench with a behavioural single-beat master
module tb_axi_master_rr_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rstn;
    logic [2*N-1:0] req_rw;
    logic [3*N-1:0] req_size;
    logic [32*N-1:0] req_addr;
    logic [W*N-1:0] req_wdata;
    logic [N-1:0]   grant, done;
    logic           r_err, r_inv;
    logic [W-1:0]   r_rdata;
    logic [1:0]     m_rw;
    logic [2:0]     m_size;
    logic [31:0]    m_addr;
    logic [W-1:0]   m_wdata;
    logic           m_clear;
    logic [W-1:0]   m_rdata;
    logic           m_wait, m_done, m_error, m_invalid;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axi_master_rr_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_req_rw      (req_rw),
        .i_req_size    (req_size),
        .i_req_addr    (req_addr),
        .i_req_wdata   (req_wdata),
        .o_req_grant   (grant),
        .o_req_done    (done),
        .o_req_error   (r_err),
        .o_req_invalid (r_inv),
        .o_req_rdata   (r_rdata),
        .o_m_rw        (m_rw),
        .o_m_size      (m_size),
        .o_m_addr      (m_addr),
        .o_m_wdata     (m_wdata),
        .o_m_clear     (m_clear),
        .i_m_rdata     (m_rdata),
        .i_m_wait      (m_wait),
        .i_m_done      (m_done),
        .i_m_error     (m_error),
        .i_m_invalid   (m_invalid)
    );

    // Behavioural master: rejects misaligned commands in the issue cycle, else busy for lat cycles
    logic        m_busy = 1'b0;
    int          m_cnt = 0;
    int          lat = 1;
    int          accepts = 0;
    logic [31:0] resp_rdata = 32'h0;
    logic        resp_err = 1'b0;
    logic        mix_addr = 1'b0;
    logic        rej, done_norm;

    function automatic logic misaligned(input logic [2:0] sz, input logic [31:0] a);
        return (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b0) || (sz == 3'd3 && a[2:0] != 3'b0);
    endfunction

    assign rej       = (m_rw == 2'b01 || m_rw == 2'b10) && misaligned(m_size, m_addr);
    assign done_norm = m_busy && (m_cnt == 0);
    assign m_done    = rej || done_norm;
    assign m_wait    = m_busy;
    assign m_error   = rej ? 1'b1 : (done_norm ? resp_err : 1'b1);
    assign m_invalid = rej ? 1'b1 : !done_norm;
    assign m_rdata   = rej ? 32'hBAD0_BAD0 :
                       (done_norm ? (resp_rdata | (mix_addr ? m_addr : 32'h0)) : 32'hFFFF_FFFF);

    always @(posedge clk) begin
        if (!rstn || m_clear) begin
            m_busy <= 1'b0;
        end else if (!m_busy && (m_rw == 2'b01 || m_rw == 2'b10) && !rej) begin
            m_busy  <= 1'b1;
            m_cnt   <= lat;
            accepts <= accepts + 1;
        end else if (m_busy && m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [1:0] rw, input logic [2:0] sz,
                           input logic [31:0] a, input logic [31:0] wd);
        req_rw[2*k +: 2]    = rw;
        req_size[3*k +: 3]  = sz;
        req_addr[32*k +: 32] = a;
        req_wdata[W*k +: W] = wd;
    endtask

    task automatic wait_grant(input int budget, output int n);
        n = 0;
        while (grant == '0 && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (done == '0 && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        req_rw = '0; req_size = '0; req_addr = '0; req_wdata = '0;
        step();
        step();
        tests++;
        if ({grant, done, m_rw, m_clear} !== '0) begin
            fails++;
            $display("FAIL reset_ctrl: got grant=%b done=%b m_rw=%b clear=%b, want all 0", grant, done, m_rw, m_clear);
        end
        tests++;
        if ({r_rdata, r_err, r_inv, m_size, m_addr, m_wdata} !== '0) begin
            fails++;
            $display("FAIL reset_data: got rdata=%h err=%b inv=%b size=%h addr=%h wdata=%h, want all 0",
                     r_rdata, r_err, r_inv, m_size, m_addr, m_wdata);
        end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_round_robin();
        int n;
        int exp_k;
        for (int k = 0; k < N; k++) set_req(k, 2'b10, 3'd2, 32'h200 + 32'(4*k), 32'h0);
        resp_rdata = 32'hA000_0000; mix_addr = 1'b1; resp_err = 1'b0; lat = 1;
        for (int t = 0; t < 5; t++) begin
            exp_k = t % N;
            wait_grant(10, n);
            tests++;
            if (grant !== 4'(1 << exp_k) || m_rw !== 2'b10 || m_addr !== 32'h200 + 32'(4*exp_k)) begin
                fails++;
                $display("FAIL rr_grant[%0d]: got grant=%b rw=%b addr=%h, want grant=%b rw=10 addr=%h",
                         t, grant, m_rw, m_addr, 4'(1 << exp_k), 32'h200 + 32'(4*exp_k));
            end
            if (t == 4) req_rw = '0;
            wait_done(10, n);
            tests++;
            if (done !== 4'(1 << exp_k) || r_rdata !== (32'hA000_0200 + 32'(4*exp_k)) || r_err !== 1'b0) begin
                fails++;
                $display("FAIL rr_done[%0d]: got done=%b rdata=%h err=%b, want done=%b rdata=%h err=0",
                         t, done, r_rdata, r_err, 4'(1 << exp_k), 32'hA000_0200 + 32'(4*exp_k));
            end
            step();
        end
    endtask

    task automatic test_write();
        int n;
        int acc0;
        acc0 = accepts;
        resp_err = 1'b0; mix_addr = 1'b0; lat = 1;
        set_req(0, 2'b01, 3'd2, 32'h100, 32'hDEAD_BEEF);
        wait_grant(10, n);
        tests++;
        if (grant !== 4'b0001 || m_rw !== 2'b01 || m_addr !== 32'h100 || m_wdata !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL wr_issue: got grant=%b rw=%b addr=%h wdata=%h, want 0001 01 00000100 deadbeef",
                     grant, m_rw, m_addr, m_wdata);
        end
        set_req(0, 2'b00, 3'd0, 32'h0, 32'h0);
        step();
        tests++;
        if (m_rw !== 2'b00 || grant !== 4'b0001) begin
            fails++;
            $display("FAIL wr_pulse: got rw=%b grant=%b in wait, want rw=00 grant=0001", m_rw, grant);
        end
        wait_done(10, n);
        tests++;
        if (n !== 2 || done !== 4'b0001 || r_err !== 1'b0 || r_inv !== 1'b0 || m_clear !== 1'b1) begin
            fails++;
            $display("FAIL wr_done: got n=%0d done=%b err=%b inv=%b clear=%b, want n=2 done=0001 err=0 inv=0 clear=1",
                     n, done, r_err, r_inv, m_clear);
        end
        tests++;
        if (accepts - acc0 !== 1) begin
            fails++;
            $display("FAIL wr_beats: got %0d master commands, want 1", accepts - acc0);
        end
        step();
        tests++;
        if ({done, m_clear, grant} !== '0) begin
            fails++;
            $display("FAIL wr_after: got done=%b clear=%b grant=%b, want all 0", done, m_clear, grant);
        end
    endtask

    task automatic test_misaligned();
        int n;
        int acc0;
        acc0 = accepts;
        set_req(1, 2'b01, 3'd1, 32'h101, 32'h0000_5555);
        wait_grant(10, n);
        tests++;
        if (grant !== 4'b0010 || m_rw !== 2'b01) begin
            fails++;
            $display("FAIL mis_issue: got grant=%b rw=%b, want 0010 01", grant, m_rw);
        end
        set_req(1, 2'b00, 3'd0, 32'h0, 32'h0);
        step();
        tests++;
        if (done !== 4'b0010 || r_err !== 1'b1 || r_inv !== 1'b1 || r_rdata !== 32'h0 || m_clear !== 1'b1) begin
            fails++;
            $display("FAIL mis_done: got done=%b err=%b inv=%b rdata=%h clear=%b, want 0010 1 1 00000000 1",
                     done, r_err, r_inv, r_rdata, m_clear);
        end
        tests++;
        if (accepts !== acc0) begin
            fails++;
            $display("FAIL mis_traffic: got %0d master commands, want 0", accepts - acc0);
        end
        step();
    endtask

    task automatic test_slverr();
        int n;
        resp_rdata = 32'h1234_5678; mix_addr = 1'b0; resp_err = 1'b1; lat = 2;
        set_req(2, 2'b10, 3'd2, 32'h300, 32'h0);
        wait_grant(10, n);
        tests++;
        if (grant !== 4'b0100) begin
            fails++;
            $display("FAIL slv_grant: got %b, want 0100", grant);
        end
        set_req(2, 2'b00, 3'd0, 32'h0, 32'h0);
        wait_done(10, n);
        tests++;
        if (done !== 4'b0100 || r_rdata !== 32'h1234_5678 || r_err !== 1'b1 || r_inv !== 1'b0) begin
            fails++;
            $display("FAIL slv_done: got done=%b rdata=%h err=%b inv=%b, want 0100 12345678 1 0",
                     done, r_rdata, r_err, r_inv);
        end
        step();
        resp_err = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        int seen;
        lat = 6;
        set_req(3, 2'b10, 3'd2, 32'h400, 32'h0);
        wait_grant(10, n);
        tests++;
        if (grant !== 4'b1000) begin
            fails++;
            $display("FAIL rst_grant: got %b, want 1000", grant);
        end
        set_req(3, 2'b00, 3'd0, 32'h0, 32'h0);
        step();
        step();
        rstn = 1'b0;
        step();
        tests++;
        if ({grant, done, m_rw, m_clear, r_rdata, r_err, r_inv, m_addr} !== '0) begin
            fails++;
            $display("FAIL rst_mid: got grant=%b done=%b rw=%b clear=%b rdata=%h err=%b inv=%b addr=%h, want all 0",
                     grant, done, m_rw, m_clear, r_rdata, r_err, r_inv, m_addr);
        end
        rstn = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (done != '0) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL rst_nodone: got %0d done cycles after abandon, want 0", seen);
        end
        lat = 1;
        for (int k = 0; k < N; k++) set_req(k, 2'b10, 3'd2, 32'h200 + 32'(4*k), 32'h0);
        wait_grant(10, n);
        tests++;
        if (grant !== 4'b0001) begin
            fails++;
            $display("FAIL rst_ptr: got first grant %b, want 0001", grant);
        end
        req_rw = '0;
        wait_done(10, n);
        tests++;
        if (done !== 4'b0001) begin
            fails++;
            $display("FAIL rst_after_done: got %b, want 0001", done);
        end
        step();
    endtask

    task automatic test_ignore_withdraw();
        int n;
        int bad;
        int got0;
        lat = 4;
        set_req(0, 2'b10, 3'd2, 32'h500, 32'h0);
        wait_grant(10, n);
        set_req(0, 2'b00, 3'd0, 32'h0, 32'h0);
        set_req(1, 2'b10, 3'd2, 32'h504, 32'h0);
        set_req(3, 2'b11, 3'd2, 32'h50C, 32'h0);
        step();
        step();
        set_req(1, 2'b00, 3'd0, 32'h0, 32'h0);
        bad = 0;
        got0 = 0;
        for (int c = 0; c < 16; c++) begin
            step();
            if (grant[1] || grant[3] || done[1] || done[3]) bad++;
            if (done[0]) got0++;
        end
        tests++;
        if (bad !== 0 || got0 !== 1) begin
            fails++;
            $display("FAIL ign_wd: got %0d grants to req1/req3 and %0d req0 dones, want 0 and 1", bad, got0);
        end
        req_rw = '0;
        lat = 1;
    endtask

    initial begin
        rstn = 1'b0;
        req_rw = '0; req_size = '0; req_addr = '0; req_wdata = '0;
        test_reset();
        test_round_robin();
        test_write();
        test_misaligned();
        test_slverr();
        test_reset_mid();
        test_ignore_withdraw();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
